// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready on both sides; iterative shift-add MUL and restoring DIV/MOD.
// Define SEQ_ALU_FAST_MUL_EN for a single-cycle combinational MUL.
//   state | meaning
//   IDLE  | waiting for a request, in_ready=1
//   BUSY  | one MUL/DIV step per cycle, counter counts down to 1
//   DONE  | result and flags held, out_valid=1 until out_ready
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             sign,
  output logic             zero,
  output logic             ovf,
  output logic             dz
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;

  localparam logic [3:0] OP_PASSA = 4'd0,  OP_PASSB = 4'd1,  OP_ADD = 4'd2,  OP_SUB = 4'd3,
                         OP_MUL   = 4'd4,  OP_DIV   = 4'd5,  OP_MOD = 4'd6,  OP_CMP = 4'd7,
                         OP_CGE   = 4'd8,  OP_CGT   = 4'd9,  OP_AND = 4'd10, OP_ORR = 4'd11,
                         OP_XOR   = 4'd12, OP_NOT   = 4'd13, OP_SHL = 4'd14, OP_SHR = 4'd15;

  logic [1:0]       state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi, lo;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   add_s;
  logic [WIDTH-1:0] sub_d;
  logic [WIDTH-1:0] s_res;
  logic             s_carry, s_ovf, s_dz, s_cmp, s_zero, s_sign, shift_big, iter;

  assign add_s     = {1'b0, a} + {1'b0, b};
  assign sub_d     = a - b;
  assign shift_big = |b[WIDTH-1:SHAMT_W];

`ifdef SEQ_ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = a * b;
  assign iter = (op == OP_DIV || op == OP_MOD) && (|b);
`else
  assign iter = (op == OP_MUL) || ((op == OP_DIV || op == OP_MOD) && (|b));
`endif

  always_comb begin
    s_res   = '0;
    s_carry = 1'b0;
    s_ovf   = 1'b0;
    s_dz    = 1'b0;
    s_cmp   = 1'b0;
    case (op)
      OP_PASSA: s_res = a;
      OP_PASSB: s_res = b;
      OP_ADD: begin
        s_res   = add_s[WIDTH-1:0];
        s_carry = add_s[WIDTH];
        s_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        s_res   = sub_d;
        s_carry = (a >= b);
        s_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_d[WIDTH-1] != a[WIDTH-1]);
      end
`ifdef SEQ_ALU_FAST_MUL_EN
      OP_MUL: begin
        s_res = prod[WIDTH-1:0];
        s_ovf = |prod[2*WIDTH-1:WIDTH];
      end
`endif
      // only reach DONE from here when the divisor is zero
      OP_DIV: begin
        s_res = '1;
        s_dz  = 1'b1;
      end
      OP_MOD: begin
        s_res = a;
        s_dz  = 1'b1;
      end
      OP_CMP, OP_CGE, OP_CGT: begin
        s_res   = a;
        s_cmp   = 1'b1;
        s_carry = (a >= b);
      end
      OP_AND: s_res = a & b;
      OP_ORR: s_res = a | b;
      OP_XOR: s_res = a ^ b;
      OP_NOT: s_res = ~a;
      OP_SHL: s_res = shift_big ? '0 : (a << b[SHAMT_W-1:0]);
      OP_SHR: s_res = shift_big ? '0 : (a >> b[SHAMT_W-1:0]);
      default: s_res = '0;
    endcase
    s_zero = s_cmp ? (a == b) : (s_res == '0);
    s_sign = s_cmp ? ($signed(a) < $signed(b)) : s_res[WIDTH-1];
  end

  // iterative step: {hi,lo} is product/multiplier for MUL, remainder/quotient for DIV
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n, div_diff, fin_res;
  logic             div_ge, is_mul;

  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], lo[WIDTH-1:1]};
  assign div_sh   = {hi, lo[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, b_q});
  assign div_diff = div_sh[WIDTH-1:0] - b_q;
  assign div_hi_n = div_ge ? div_diff : div_sh[WIDTH-1:0];
  assign div_lo_n = {lo[WIDTH-2:0], div_ge};
  assign is_mul   = (op_q == OP_MUL);
  assign fin_res  = is_mul ? mul_lo_n : ((op_q == OP_DIV) ? div_lo_n : div_hi_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      result <= '0;
      carry  <= 1'b0;
      sign   <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q <= op;
          a_q  <= a;
          b_q  <= b;
          if (iter) begin
            state <= BUSY;
            cnt   <= CNT_W'(WIDTH);
            hi    <= '0;
            lo    <= (op == OP_MUL) ? b : a;
          end else begin
            state  <= DONE;
            result <= s_res;
            carry  <= s_carry;
            sign   <= s_sign;
            zero   <= s_zero;
            ovf    <= s_ovf;
            dz     <= s_dz;
          end
        end
        BUSY: begin
          hi  <= is_mul ? mul_hi_n : div_hi_n;
          lo  <= is_mul ? mul_lo_n : div_lo_n;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state  <= DONE;
            result <= fin_res;
            carry  <= 1'b0;
            sign   <= fin_res[WIDTH-1];
            zero   <= (fin_res == '0);
            ovf    <= is_mul && (|mul_hi_n);
            dz     <= 1'b0;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors with hand-computed results for seq_alu at WIDTH=32.
// Honours SEQ_ALU_FAST_MUL_EN for the expected MUL latency.
module tb_seq_alu;
  localparam logic [3:0] OP_PASSA = 4'd0,  OP_PASSB = 4'd1,  OP_ADD = 4'd2,  OP_SUB = 4'd3,
                         OP_MUL   = 4'd4,  OP_DIV   = 4'd5,  OP_MOD = 4'd6,  OP_CMP = 4'd7,
                         OP_CGE   = 4'd8,  OP_CGT   = 4'd9,  OP_AND = 4'd10, OP_ORR = 4'd11,
                         OP_XOR   = 4'd12, OP_NOT   = 4'd13, OP_SHL = 4'd14, OP_SHR = 4'd15;
`ifdef SEQ_ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [3:0]  op = '0;
  logic [31:0] a = '0, b = '0, result;
  logic        carry, sign, zero, ovf, dz;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry(carry),
    .sign(sign), .zero(zero), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_pop", in_ready, 1'b1);
  endtask

  // run one op and check result, flags {carry,sign,zero,ovf,dz} and latency
  task automatic run(input string tag, input logic [3:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp_res,
                     input logic [4:0] exp_flags, input int exp_lat);
    int lat;
    accept(o, x, y);
    wait_done(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_flags"}, {carry, sign, zero, ovf, dz}, exp_flags);
    pop();
  endtask

  initial begin
    int lat;
    int bad;
    logic [31:0] held;
    #12 rst = 1'b0;
    #10;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 32'h0);

    //                                           c s z o d
    run("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 5'b01010, 1);

    // reset in the middle of a DIV
    accept(OP_DIV, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_result", result, 32'h0);
    check("abort_flags", {carry, sign, zero, ovf, dz}, 5'b00000);
    @(posedge clk); #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) bad++;
    end
    check("abort_no_pulse", bad, 0);

    run("div",      OP_DIV, 32'd100, 32'd7, 32'd14, 5'b00000, 33);
    run("mod",      OP_MOD, 32'd100, 32'd7, 32'd2,  5'b00000, 33);
    run("div_big",  OP_DIV, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 5'b00000, 33);
    run("div_z",    OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 5'b01001, 1);
    run("mod_z",    OP_MOD, 32'd5, 32'd0, 32'd5, 5'b00001, 1);

    run("add_carry", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b10100, 1);
    run("sub_neg",   OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 5'b01000, 1);
    run("sub_ovf",   OP_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 5'b10010, 1);

    run("mul_ovf",  OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 5'b00110, MUL_LAT);
    run("mul_small", OP_MUL, 32'd3, 32'd5, 32'd15, 5'b00000, MUL_LAT);
    run("mul_max",  OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 5'b00010, MUL_LAT);

    run("cgt",      OP_CGT, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 5'b11000, 1);
    run("cmp_eq",   OP_CMP, 32'd5, 32'd5, 32'd5, 5'b10100, 1);
    run("cge_lt",   OP_CGE, 32'd2, 32'd9, 32'd2, 5'b01000, 1);

    run("pass_a",   OP_PASSA, 32'h1234_5678, 32'h9, 32'h1234_5678, 5'b00000, 1);
    run("pass_b",   OP_PASSB, 32'h1, 32'hC000_0000, 32'hC000_0000, 5'b01000, 1);
    run("and",      OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 5'b01000, 1);
    run("orr",      OP_ORR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 5'b00000, 1);
    run("xor",      OP_XOR, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0, 5'b00100, 1);
    run("not",      OP_NOT, 32'h0000_FFFF, 32'h0, 32'hFFFF_0000, 5'b01000, 1);
    run("shl_big",  OP_SHL, 32'd1, 32'h20, 32'h0, 5'b00100, 1);
    run("shl_31",   OP_SHL, 32'd1, 32'd31, 32'h8000_0000, 5'b01000, 1);

    // out_ready while idle must not disturb anything
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_out_ready", {in_ready, out_valid}, 2'b10);

    // backpressure: hold the result while new operands are presented
    accept(OP_SHR, 32'h8000_0000, 32'd4);
    wait_done(lat);
    check("bp_lat", lat, 1);
    held = result;
    check("bp_res", held, 32'h0800_0000);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      op = OP_ADD; a = 32'h1111 * i; b = 32'h7; in_valid = 1'b1;
      @(posedge clk); #1;
      if (result !== 32'h0800_0000 || !out_valid || in_ready ||
          {carry, sign, zero, ovf, dz} !== 5'b00000) bad++;
    end
    in_valid = 1'b0;
    check("bp_stable", bad, 0);
    pop();
    check("bp_out_valid_low", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
